// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I-subset core: sequences the shared
// ALU, memory port and register file over several cycles per instruction.
module multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state;
    state_t next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next          = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        trap          = 1'b0;
        state_dbg     = state;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next = DECODE;
            end
            DECODE: begin
                // Speculatively computes the branch target into ALUOut.
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:      next = EXEC_R;
                    OP_I:      next = (funct3 == 3'b000) ? EXEC_I : TRAP;
                    OP_LOAD,
                    OP_STORE:  next = (funct3 == 3'b010) ? MEM_ADDR : TRAP;
                    OP_BRANCH: next = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
                    default:   next = TRAP;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                next      = opcode[5] ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) next = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                next       = FETCH;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) next = FETCH;
            end
            EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
                next      = R_WB;
            end
            EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                next      = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next       = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 2'b01;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 1'b1;
                branch_ne     = funct3[0];
                instr_done    = 1'b1;
                next          = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                next = TRAP;
            end
        endcase

        // Reset masks every output so an abandoned instruction cannot write.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            branch_ne     = 1'b0;
            pc_src        = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            instr_done    = 1'b0;
            trap          = 1'b0;
            state_dbg     = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: expands each instruction into its expected
// per-cycle phase sequence and compares every cycle against the DUT.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, pc_src, i_or_d;
    logic       mem_read, mem_write, ir_write, reg_write, mem_to_reg;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       instr_done, trap;
    logic [3:0] state_dbg;

    multicycle_control #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .pc_src(pc_src), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .trap(trap), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, bne, pcs, iod, mr, mw, irw, rw, m2r;
        logic [1:0] a, b, op;
        logic done, trp;
    } vec_t;

    typedef struct packed {
        vec_t v;
        logic rdy;
        logic rst;
    } ent_t;

    ent_t q[$];
    vec_t cur;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   since_done = 0;
    int   last_lat = 0;

    // Spec table of outputs for one cycle spent in phase ph.
    function automatic vec_t expect_for(int ph, bit rdy, bit f0);
        vec_t v;
        v = '0;
        v.st = ph[3:0];
        case (ph)
            0:  begin v.mr = 1; v.b = 2'b01; v.irw = rdy; v.pcw = rdy; end
            1:  begin v.a = 2'b10; v.b = 2'b10; end
            2:  begin v.a = 2'b01; v.b = 2'b10; end
            3:  begin v.mr = 1; v.iod = 1; end
            4:  begin v.rw = 1; v.m2r = 1; v.done = 1; end
            5:  begin v.mw = 1; v.iod = 1; v.done = rdy; end
            6:  begin v.a = 2'b01; v.op = 2'b10; end
            7:  begin v.a = 2'b01; v.b = 2'b10; end
            8:  begin v.rw = 1; v.done = 1; end
            9:  begin v.a = 2'b01; v.op = 2'b01; v.pcwc = 1; v.pcs = 1; v.bne = f0; v.done = 1; end
            default: v.trp = 1;
        endcase
        return v;
    endfunction

    function automatic void push(int ph, bit rdy);
        ent_t e;
        e.v   = expect_for(ph, rdy, funct3[0]);
        e.rdy = rdy;
        e.rst = 1'b0;
        q.push_back(e);
    endfunction

    function automatic void push_rst(bit rdy);
        ent_t e;
        e = '0;
        e.rdy = rdy;
        e.rst = 1'b1;
        q.push_back(e);
    endfunction

    task automatic run_queue();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            mem_ready = e.rdy;
            reset     = e.rst;
            cur       = e.v;
            chk_en    = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // Builds the phase sequence for one instruction, stretching memory phases by wait cycles.
    task automatic do_instr(input logic [6:0] opc, input logic [2:0] f3,
                            input int fw, input int mw, input int hold);
        opcode = opc;
        funct3 = f3;
        for (int i = 0; i < fw; i++) push(0, 0);
        push(0, 1);
        push(1, 1);
        if (opc == 7'b0110011) begin
            push(6, 1); push(8, 1);
        end else if (opc == 7'b0010011 && f3 == 3'b000) begin
            push(7, 1); push(8, 1);
        end else if (opc == 7'b0000011 && f3 == 3'b010) begin
            push(2, 1);
            for (int i = 0; i < mw; i++) push(3, 0);
            push(3, 1); push(4, 1);
        end else if (opc == 7'b0100011 && f3 == 3'b010) begin
            push(2, 1);
            for (int i = 0; i < mw; i++) push(5, 0);
            push(5, 1);
        end else if (opc == 7'b1100011 && f3 < 3'd2) begin
            push(9, 1);
        end else begin
            for (int i = 0; i < hold; i++) push(15, i[0]);
            push_rst(1);
        end
        run_queue();
    endtask

    task automatic check_lat(input string name, input int want);
        checks++;
        if (last_lat == want) passes++;
        else $display("FAIL latency %s: got %0d cycles, expected %0d", name, last_lat, want);
    endtask

    always @(negedge clk) begin
        vec_t got;
        if (chk_en) begin
            got = {state_dbg, pc_write, pc_write_cond, branch_ne, pc_src, i_or_d,
                   mem_read, mem_write, ir_write, reg_write, mem_to_reg,
                   alu_src_a, alu_src_b, alu_op, instr_done, trap};
            checks++;
            if (got === cur) passes++;
            else $display("FAIL outputs cyc%0d: got %h, expected %h", cyc, got, cur);
            if (got.mr && got.mw) $display("FAIL exclusive strobes cyc%0d: mem_read and mem_write both high", cyc);
            cyc++;
            if (reset) since_done = 0;
            else begin
                since_done++;
                if (instr_done) begin
                    last_lat   = since_done;
                    since_done = 0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        funct3 = 3'b000;
        push_rst(1);
        push_rst(0);
        run_queue();

        do_instr(7'b0110011, 3'b000, 0, 0, 0);     // add
        check_lat("add", 4);
        do_instr(7'b0000011, 3'b010, 0, 2, 0);     // lw, 2 wait cycles
        check_lat("lw_wait2", 7);
        do_instr(7'b1100011, 3'b001, 0, 0, 0);     // bne
        check_lat("bne", 3);
        do_instr(7'b1100011, 3'b000, 1, 0, 0);     // beq, 1 fetch wait
        check_lat("beq_fwait1", 4);
        do_instr(7'b0010011, 3'b000, 0, 0, 0);     // addi
        check_lat("addi", 4);
        do_instr(7'b0100011, 3'b010, 0, 0, 0);     // sw
        check_lat("sw", 4);
        do_instr(7'b0100011, 3'b010, 2, 1, 0);     // sw with waits
        check_lat("sw_waits", 7);
        do_instr(7'b0110011, 3'b100, 0, 0, 0);     // xor
        do_instr(7'b0110011, 3'b101, 0, 0, 0);     // srl
        do_instr(7'b0110011, 3'b001, 0, 0, 0);     // sll
        do_instr(7'b0000011, 3'b010, 0, 0, 0);     // lw no wait
        check_lat("lw", 5);

        do_instr(7'b1111111, 3'b000, 0, 0, 20);    // illegal opcode
        do_instr(7'b0010011, 3'b001, 0, 0, 3);     // addi bad funct3
        do_instr(7'b0000011, 3'b000, 0, 0, 3);     // lw bad funct3
        do_instr(7'b1100011, 3'b100, 0, 0, 3);     // branch bad funct3

        // Reset lands on the MEM_WR cycle with mem_ready high.
        opcode = 7'b0100011;
        funct3 = 3'b010;
        push(0, 1); push(1, 1); push(2, 1);
        push_rst(1);
        run_queue();
        do_instr(7'b0110011, 3'b000, 0, 0, 0);
        check_lat("add_after_reset", 4);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I-subset core; sequences the shared ALU, the memory port and the register file over several cycles per instruction.
- Drives the 2-bit ALU-op code consumed by the ALU control decoder: 00 = add, 01 = sub, 10 = decode funct3/funct7.
- Supported instructions: add, sub, xor, srl, sll, addi, lw, sw, beq and bne.
- Any other encoding parks the FSM in a trap state.

Parameters:
- RESET_STATE, 4'd0: state encoding loaded on reset (FETCH). Must not be changed without also changing the state table.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instruction register bits [6:0]; stable from the DECODE state onward.
- funct3  in  3  instruction register bits [14:12].
- mem_ready  in  1  memory handshake; the access completes in the cycle it is high.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if the branch condition holds (datapath evaluates zero ^ branch_ne).
- branch_ne  out  1  1 = bne, 0 = beq; valid while pc_write_cond=1.
- pc_src  out  1  0 = ALU result, 1 = ALUOut register.
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  2  ALU A source: 00 = PC, 01 = rs1, 10 = old PC.
- alu_src_b  out  2  ALU B source: 00 = rs2, 01 = const 4, 10 = immediate.
- alu_op  out  2  to the ALU control decoder.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- trap  out  1  illegal instruction; held until reset.
- state_dbg  out  4  current state encoding.

Behaviour:
- Moore FSM; all outputs are decoded from the state register only, except the mem_ready-qualified strobes listed below.
- Unlisted outputs are 0 in every state.
- Reset: synchronous. The next edge with reset=1 loads FETCH. While reset=1, all outputs are forced to 0 (state_dbg shows 0). Reset mid-instruction abandons it; no partial write occurs after that edge.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, R_WB=8, BRANCH=9, TRAP=15.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_src=0.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I if funct3=000, else TRAP.
    - 0000011 or 0100011 → MEM_ADDR, only if funct3=010, else TRAP.
    - 1100011 → BRANCH if funct3 is 000 or 001, else TRAP.
    - Any other opcode → TRAP.
- MEM_ADDR:
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00.
  - Next state: MEM_RD if opcode[5]=0, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1. Next state FETCH.
- MEM_WR:
  - Outputs: mem_write=1, i_or_d=1.
  - instr_done equals mem_ready.
  - Waits for mem_ready, then goes to FETCH.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10. Next state R_WB.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=00. Next state R_WB.
- R_WB: reg_write=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH:
  - Outputs: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=1, branch_ne=funct3[0], instr_done=1.
  - Next state FETCH.
- TRAP: trap=1, all strobes 0. Stays in TRAP until reset.
- Latency with mem_ready tied high:
  - branch: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle with mem_ready=0 adds exactly one cycle.
- mem_read and mem_write are never high in the same cycle.
- reg_write is never high in the same cycle as pc_write or pc_write_cond.
- An unreachable state encoding goes to TRAP on the next edge.

Test Plan:
- Hold reset=1 for 2 cycles, then release with mem_ready=1 → state_dbg=0 and mem_read=1 in the first cycle; all outputs 0 while reset was high.
- Run add (opcode 0110011) with mem_ready=1 → states 0,1,6,8; alu_op=10 in EXEC_R; reg_write=1 and instr_done=1 only in cycle 4.
- Run lw (0000011, funct3=010) with mem_ready low for 2 cycles in MEM_RD → states 0,1,2,3,3,3,4; mem_to_reg=1 with reg_write in MEM_WB; 7 cycles total.
- Run bne (1100011, funct3=001) → 3 cycles; in BRANCH: alu_op=01, pc_write_cond=1, branch_ne=1, pc_src=1.
- Run opcode 1111111 → TRAP after DECODE; trap=1 held for 20 cycles regardless of mem_ready; reset returns the FSM to FETCH.
- Assert reset in the MEM_WR cycle with mem_ready=1 → mem_write=0 that cycle; FETCH on the next cycle.
